// File: rtl/fd_stage_pkg.sv
// Shared definitions for the fetch-to-decode stage: instruction field
// positions, opcode constants and small decode helpers.
package fd_stage_pkg;

  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP_WORD = 32'h0000_0000;

  // Field bit positions within the instruction word
  localparam int OPC_HI    = 31;
  localparam int OPC_LO    = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int RS_HI     = 21;
  localparam int RS_LO     = 17;
  localparam int RT_HI     = 16;
  localparam int RT_LO     = 12;
  localparam int SHAMT_HI  = 11;
  localparam int SHAMT_LO  = 7;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;
  localparam int IMM_HI    = 16;
  localparam int TARGET_HI = 26;

  typedef enum logic [4:0] {
    OP_ALU  = 5'b00000,
    OP_J    = 5'b00001,
    OP_BNE  = 5'b00010,
    OP_JAL  = 5'b00011,
    OP_JR   = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_BLT  = 5'b00110,
    OP_SW   = 5'b00111,
    OP_LW   = 5'b01000,
    OP_SETX = 5'b10101,
    OP_BEX  = 5'b10110
  } opcode_e;

  // Opcodes that carry a 17-bit immediate
  function automatic logic op_is_itype(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW) ||
           (op == OP_BNE)  || (op == OP_BLT);
  endfunction

  // Opcodes whose second register read uses the rd field instead of rt
  function automatic logic op_reads_rd(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/fd_skid_buffer.sv
// Two-entry in-order buffer (skid buffer). Push/pop arrive pre-qualified;
// flush empties the buffer and overrides any push or pop in the same cycle.
// rdata shows the head entry, or zero when empty.
module fd_skid_buffer #(
  parameter int W = 44
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem0, mem1;
  logic         head, tail;
  logic [1:0]   count_q;

  // Pointer, occupancy and storage update; flush wins over push/pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem0    <= '0;
      mem1    <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        if (tail) mem1 <= wdata;
        else      mem0 <= wdata;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry, forced to zero when the buffer is empty
  always_comb begin
    rdata = '0;
    if (count_q != 2'd0) rdata = head ? mem1 : mem0;
  end

  assign count = count_q;

endmodule

// File: rtl/fd_stage.sv
// Fetch-to-decode pipeline stage: buffers fetched instructions in a
// two-entry skid buffer and slices the head entry into decode fields.
// Optional feature macro: FD_STALL_COUNT_EN adds a saturating 32-bit
// stall_count output counting cycles with out_valid && !out_ready.
//
// Handshake: a transfer occurs on a rising edge where valid && ready are
// both high and flush is low; valid never waits on ready, ready depends
// only on registered occupancy, and data holds while valid && !ready.
module fd_stage
  import fd_stage_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_insn,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      shamt,
  output logic [4:0]      aluop,
  output logic [4:0]      rs2_sel,
  output logic [16:0]     imm17,
  output logic [26:0]     target,
  output logic            is_itype
`ifdef FD_STALL_COUNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  localparam int ENTRY_W = INSN_W + PC_W;

  logic [1:0]         count;
  logic [ENTRY_W-1:0] head_entry;
  logic               push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  fd_skid_buffer #(.W(ENTRY_W)) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({in_pc, in_insn}),
    .rdata   (head_entry),
    .count   (count)
  );

  assign out_insn = head_entry[INSN_W-1:0];
  assign out_pc   = head_entry[ENTRY_W-1:INSN_W];

  // Decode fields are plain slices of the head word (zero when empty)
  always_comb begin
    opcode   = out_insn[OPC_HI:OPC_LO];
    rd       = out_insn[RD_HI:RD_LO];
    rs       = out_insn[RS_HI:RS_LO];
    rt       = out_insn[RT_HI:RT_LO];
    shamt    = out_insn[SHAMT_HI:SHAMT_LO];
    aluop    = out_insn[ALUOP_HI:ALUOP_LO];
    imm17    = out_insn[IMM_HI:0];
    target   = out_insn[TARGET_HI:0];
    is_itype = op_is_itype(opcode);
    rs2_sel  = op_reads_rd(opcode) ? rd : rt;
  end

`ifdef FD_STALL_COUNT_EN
  // Saturating count of back-pressured cycles; flush does not clear it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                   stall_count <= '0;
    else if (out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF))
                                                    stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fd_stage.sv
// Self-checking bench for fd_stage: directed scenarios plus randomized
// traffic, with a queue-based reference model and a negedge monitor.
module tb_fd_stage;

  localparam int PC_W = 12;
  localparam int EW   = 32 + PC_W;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_insn, out_insn;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0]      opcode, rd, rs, rt, shamt, aluop, rs2_sel;
  logic [16:0]     imm17;
  logic [26:0]     target;
  logic            is_itype;
  logic [31:0]     stall_count;
`ifndef FD_STALL_COUNT_EN
  assign stall_count = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: buffered entries {pc, insn} in order
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_stall;

  fd_stage #(.PC_W(PC_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_insn   (in_insn),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .shamt     (shamt),
    .aluop     (aluop),
    .rs2_sel   (rs2_sel),
    .imm17     (imm17),
    .target    (target),
    .is_itype  (is_itype)
`ifdef FD_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffer behaviour at the architectural level: a FIFO of depth two.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_stall = '0;
    end else begin
      bit can_push, can_pop;
      can_push = in_valid && (exp_q.size() < 2) && !flush;
      can_pop  = (exp_q.size() > 0) && out_ready && !flush;
      if (exp_q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) exp_q.delete();
      else begin
        if (can_pop) void'(exp_q.pop_front());
        if (can_push) exp_q.push_back({in_pc, in_insn});
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [31:0]     w;
    logic [PC_W-1:0] p;
    logic [4:0]      op, e_rd, e_rt;
    bit              it, rdsel;
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("out_valid", out_valid, exp_q.size() > 0);
`ifdef FD_STALL_COUNT_EN
    chk("stall_count", stall_count, m_stall);
`endif
    if (exp_q.size() > 0) {p, w} = exp_q[0];
    else begin
      p = '0;
      w = '0;
    end
    op    = w[31:27];
    e_rd  = w[26:22];
    e_rt  = w[16:12];
    it    = op inside {5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110};
    rdsel = op inside {5'b00111, 5'b00010, 5'b00110, 5'b00100};
    chk("out_insn", out_insn, w);
    chk("out_pc", out_pc, p);
    chk("fields", {opcode, rd, rs, rt, shamt, aluop},
        {op, e_rd, w[21:17], e_rt, w[11:7], w[6:2]});
    chk("imm17", imm17, w[16:0]);
    chk("target", target, w[26:0]);
    chk("is_itype", is_itype, it);
    chk("rs2_sel", rs2_sel, rdsel ? e_rd : e_rt);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [31:0] insn, input logic [PC_W-1:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_insn   = insn;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  logic [4:0] op_tab [11];

  initial begin
    logic [31:0] w;
    op_tab = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
               5'b00110, 5'b00111, 5'b01000, 5'b10101, 5'b10110};

    // Reset asserted while fetch is offering an instruction
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'h28A2_0005;
    in_pc     = 12'd3;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fields", {out_insn, opcode, imm17, rs2_sel, is_itype}, '0);
    chk("rst_stall", stall_count, 32'd0);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single addi
    drive(1, 32'h28A2_0005, 12'd3, 1, 0);
    @(negedge clock);
    chk("addi_opcode", opcode, 5'b00101);
    chk("addi_rd", rd, 5'd2);
    chk("addi_rs", rs, 5'd17);
    chk("addi_imm", imm17, 17'd5);
    chk("addi_itype", is_itype, 1'b1);
    chk("addi_pc", out_pc, 12'd3);
    drive(0, 0, 0, 1, 0);

    // Back-pressure: A, B accepted, C refused
    drive(1, 32'h0000_0A0A, 12'd10, 0, 0);
    drive(1, 32'h0000_0B0B, 12'd11, 0, 0);
    @(negedge clock);
    chk("bp_in_ready", in_ready, 1'b0);
    drive(1, 32'h0000_0C0C, 12'd12, 0, 0);
    @(negedge clock);
    chk("bp_head_a", out_insn, 32'h0000_0A0A);
    drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("bp_head_b", out_insn, 32'h0000_0B0B);
    drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("bp_empty", out_valid, 1'b0);

    // Simultaneous push and pop at occupancy one
    drive(1, 32'h1000_0000, 12'd100, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'h1000_0000 + i, 12'(100 + i), 1, 0);
      @(negedge clock);
      chk("pp_head", out_insn, 32'h1000_0000 + i);
      chk("pp_ready", in_ready, 1'b1);
    end
    drive(0, 0, 0, 1, 0);

    // Flush while full with an input offered
    drive(1, 32'h2000_0001, 12'd1, 0, 0);
    drive(1, 32'h2000_0002, 12'd2, 0, 0);
    drive(1, 32'hDEAD_BEEF, 12'd9, 0, 1);
    @(negedge clock);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("fl_still_empty", out_valid, 1'b0);

    // sw decode and stall counting from a fresh reset
    do_reset();
    drive(1, 32'h3880_0004, 12'd7, 0, 0);
    @(negedge clock);
    chk("sw_rs2_sel", rs2_sel, 5'd2);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0);
`ifdef FD_STALL_COUNT_EN
    @(negedge clock);
    chk("stall_7", stall_count, 32'd7);
`endif
    drive(0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[31:27] = op_tab[$urandom_range(0, 10)];
      drive($urandom_range(0, 3) != 0, w, 12'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("final_empty", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fd_stage.md
# fd_stage

Fetch-to-decode pipeline stage for the 32-bit five-stage processor. Accepts fetched instructions and their PC over a valid/ready handshake, buffers up to two entries in a skid buffer, and presents the head entry's decoded fields to the decode logic, including the 17-bit immediate consumed by the sign-extension unit. Provides a synchronous flush for taken branches and jumps.

## Interface
- PC_W, 12, width of the program counter / instruction memory address
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; equals (count != 2), registered state only
- in_insn  in  32  fetched instruction word
- in_pc  in  PC_W  PC of in_insn
- flush  in  1  discard all buffered entries and this cycle's input
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- out_insn  out  32  head instruction (0 when empty)
- out_pc  out  PC_W  head PC (0 when empty)
- opcode  out  5  out_insn[31:27]
- rd, rs, rt  out  5 each  out_insn[26:22], [21:17], [16:12]
- shamt, aluop  out  5 each  out_insn[11:7], [6:2]
- rs2_sel  out  5  second register-file read address (see Operation)
- imm17  out  17  out_insn[16:0], to sign-extension unit
- target  out  27  out_insn[26:0]
- is_itype  out  1  opcode in {00101 addi, 00111 sw, 01000 lw, 00010 bne, 00110 blt}
- stall_count  out  32  present only with FD_STALL_COUNT_EN

## Operation
- Two-entry in-order buffer; count in {0,1,2}; head pointer and tail pointer wrap mod 2.
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- Push and pop in the same cycle: count unchanged, order preserved (count=1: new entry becomes head next cycle; count=2 cannot push).
- flush: next edge sets count=0, both pointers 0; same-cycle push and pop are discarded; flush overrides everything.
- Empty: out_valid=0, out_insn=0, out_pc=0, so all decoded fields are 0 (nop encoding).
- Decoded fields are combinational slices of the head entry; no extra decode register.
- rs2_sel = rd when opcode in {00111 sw, 00010 bne, 00110 blt, 00100 jr}, else rt.
- out_insn/out_pc/out_valid hold stable while out_valid && !out_ready.
- Reset (asynchronous assert): count=0, pointers=0, storage=0; thus out_valid=0, all decoded outputs 0, in_ready=1, stall_count=0. Deassertion sampled by clock; no accept on the deasserting edge is guaranteed.

## Timing
- Latency: instruction accepted at edge N is on out_* after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle with out_ready held high.
- in_ready depends only on registered count; no combinational path out_ready -> in_ready.
- Combinational paths: buffer storage -> decoded outputs only.
- Back-pressure: with out_ready low, two further accepts fill the buffer; in_ready falls the cycle after the second accept.

## Configuration
- FD_STALL_COUNT_EN defined: 32-bit stall_count increments every cycle with out_valid && !out_ready, saturates at 0xFFFFFFFF, cleared only by reset (not by flush).
- Undefined: stall_count port and counter absent; all other behaviour identical.

## Structure
- Shared package: field bit positions, opcode constants (ALU 00000, J 00001, BNE 00010, JAL 00011, JR 00100, ADDI 00101, BLT 00110, SW 00111, LW 01000, SETX 10101, BEX 10110), NOP word 32'h0.
- One sub-module: fd_skid_buffer (2-entry, width 32+PC_W, push/pop/flush, count); fd_stage wraps it with field decode and optional counter.

## Test plan
- Reset with in_valid=1, in_insn=32'h28A2_0005 -> out_valid=0, all fields 0, in_ready=1, stall_count=0.
- Push addi 32'h28A2_0005 at PC 3, out_ready=1 -> next cycle opcode=00101, rd=2, rs=17, imm17=5, is_itype=1, out_pc=3.
- out_ready=0, push A,B,C on consecutive cycles -> A,B buffered, in_ready=0 from cycle after B, C not accepted; release out_ready -> A then B, no loss or duplication.
- count=1, simultaneous push and pop for 10 cycles -> count stays 1, instructions emerge in order one per cycle.
- count=2 with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not seen later.
- sw 32'h3880_0004 -> rs2_sel=rd=2; with FD_STALL_COUNT_EN and 7 stalled cycles -> stall_count=7.
